// File: rtl/gshare_bht.sv
// gshare branch predictor: GHR-hashed table of saturating counters with
// speculative history, mispredict recovery and saturating performance counters.
module gshare_bht #(
  parameter int unsigned IDX_WIDTH  = 6,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned GHR_WIDTH  = 6,
  parameter int unsigned INIT_CTR   = 1,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  lookup_valid,
  input  logic [IDX_WIDTH-1:0]  lookup_pc_idx,
  output logic                  pred_taken,
  output logic [IDX_WIDTH-1:0]  pred_index,
  output logic [GHR_WIDTH-1:0]  pred_ghr,
  input  logic                  commit_valid,
  input  logic [IDX_WIDTH-1:0]  commit_index,
  input  logic                  commit_taken,
  input  logic                  commit_mispredict,
  input  logic [GHR_WIDTH-1:0]  commit_ghr,
  output logic [STAT_WIDTH-1:0] stat_lookups,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int unsigned DEPTH = 1 << IDX_WIDTH;
  localparam logic [CTR_WIDTH-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]  CTR_INIT = CTR_WIDTH'(INIT_CTR);
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [CTR_WIDTH-1:0]  table_q [DEPTH];
  logic [CTR_WIDTH-1:0]  table_d [DEPTH];
  logic [GHR_WIDTH-1:0]  ghr_q, ghr_d;
  logic [STAT_WIDTH-1:0] stat_lookups_q, stat_lookups_d;
  logic [STAT_WIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;
  logic                  lookup_acc, commit_acc, recover;
  logic [CTR_WIDTH-1:0]  commit_ctr, commit_ctr_nxt;

  // Combinational prediction: GHR zero-extended into the index LSBs.
  always_comb begin
    pred_index = lookup_pc_idx ^ IDX_WIDTH'(ghr_q);
    pred_ghr   = ghr_q;
    pred_taken = table_q[pred_index][CTR_WIDTH-1];
  end

  always_comb begin
    table_d            = table_q;
    ghr_d              = ghr_q;
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    lookup_acc         = lookup_valid && rdy;
    commit_acc         = commit_valid && rdy;
    recover            = commit_acc && commit_mispredict;
    commit_ctr         = table_q[commit_index];
    commit_ctr_nxt     = commit_ctr;

    if (commit_taken) begin
      if (commit_ctr != CTR_MAX) commit_ctr_nxt = commit_ctr + CTR_WIDTH'(1);
    end else begin
      if (commit_ctr != '0) commit_ctr_nxt = commit_ctr - CTR_WIDTH'(1);
    end
    if (commit_acc) table_d[commit_index] = commit_ctr_nxt;

    // Recovery wins over a same-cycle speculative shift.
    if (recover) begin
      ghr_d = GHR_WIDTH'({commit_ghr, commit_taken});
    end else if (lookup_acc) begin
      ghr_d = GHR_WIDTH'({ghr_q, pred_taken});
    end

    if (lookup_acc && (stat_lookups_q != STAT_MAX))
      stat_lookups_d = stat_lookups_q + STAT_WIDTH'(1);
    if (recover && (stat_mispredicts_q != STAT_MAX))
      stat_mispredicts_d = stat_mispredicts_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_INIT;
      ghr_q              <= '0;
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= table_d[i];
      ghr_q              <= ghr_d;
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
